// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 16;
  localparam int DIGIT_DEF = 4;

  // Number of digit slices needed to cover the full operand width.
  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter width for n slices; a single-slice build still gets a 1-bit counter.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NDIG  = ndig(WIDTH_DEF, DIGIT_DEF);
  localparam int CNT_W = cnt_w(NDIG);

endpackage

// File: rtl/serial_subtractor_digit_sub.sv
// One DIGIT-bit slice of subtraction: d = x - y - bin, bo set on underflow.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module digit_sub #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  logic [DIGIT:0] full;

  // One extra bit catches the borrow: a negative slice result wraps with its top bit set.
  assign full = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bin};
  assign d    = full[DIGIT-1:0];
  assign bo   = full[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial a - b, one DIGIT-bit slice per cycle LSB first, borrow rippled through a flop.
// Latency: NDIG cycles from accept to out_valid; one op per NDIG+2 cycles with out_ready high.
// Backpressure: result held in DONE until out_ready; in_ready low whenever not IDLE.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  // WIDTH must be a whole multiple of DIGIT; the slice count truncates otherwise.
  localparam int N  = ndig(WIDTH, DIGIT);
  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             bout_q;
  logic             ovf_q;
  logic             a_msb;
  logic             b_msb;
  logic [DIGIT-1:0] slice_d;
  logic             slice_bo;
  logic             accept;
  logic             last_slice;

  assign accept     = in_valid && (state == IDLE);
  assign last_slice = (state == RUN) && (cnt == LAST);

  digit_sub #(.DIGIT(DIGIT)) u_digit_sub (
    .x   (a_sr[DIGIT-1:0]),
    .y   (b_sr[DIGIT-1:0]),
    .bin (borrow),
    .d   (slice_d),
    .bo  (slice_bo)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: accept in IDLE, walk NDIG slices in RUN, hand off in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = RUN;
      RUN:     if (last_slice) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, then shift one slice per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      cnt     <= '0;
      borrow  <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      cnt    <= '0;
      borrow <= 1'b0;
      a_msb  <= a[WIDTH-1];
      b_msb  <= b[WIDTH-1];
    end else if (state == RUN) begin
      a_sr    <= a_sr >> DIGIT;
      b_sr    <= b_sr >> DIGIT;
      diff_sr <= WIDTH'({slice_d, diff_sr} >> DIGIT);
      borrow  <= slice_bo;
      cnt     <= cnt + CW'(1);
      if (last_slice) begin
        bout_q <= slice_bo;
        // Signed overflow: operands of opposite sign and the result sign differs from a.
        ovf_q  <= (a_msb != b_msb) && (slice_d[DIGIT-1] != a_msb);
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign diff      = diff_sr;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table plus multi-cycle corner sequences.
// Latency: expects NDIG = 4 cycles accept-to-result and one result per 6 cycles when streaming.
// Backpressure: exercises held results under out_ready low and ignored in_valid outside IDLE.
module tb_serial_subtractor;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       nm;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Launch one operation and wait (bounded) for its result; returns at the first DONE negedge.
  task automatic run_op(input logic [15:0] a_i, input logic [15:0] b_i,
                        output logic [15:0] d_o, output logic bo_o, output logic ov_o,
                        output int lat);
    @(negedge clk);
    a = a_i;
    b = b_i;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      @(negedge clk);
      lat++;
    end
    chk("result_seen", {31'b0, out_valid}, 32'd1);
    d_o  = diff;
    bo_o = bout;
    ov_o = ovf;
  endtask

  logic [15:0] rd;
  logic        rbo;
  logic        rov;
  int          rlat;

  logic [15:0] q_d[$];
  logic        q_bo[$];
  logic        q_ov[$];

  initial begin
    vecs[0] = '{"one_minus_one",   16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b0};
    vecs[1] = '{"zero_minus_one",  16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{"min_minus_one",   16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
    vecs[3] = '{"adder_rt_wrap",   16'hFFFE, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
    vecs[4] = '{"adder_rt_plain",  16'h01E0, 16'h00F0, 16'h00F0, 1'b0, 1'b0};
    vecs[5] = '{"max_minus_neg1",  16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1};
    vecs[6] = '{"equal",           16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0};
    vecs[7] = '{"zero_minus_min",  16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b1};
    vecs[8] = '{"ffff_minus_zero", 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;

    // Reset values while reset is held.
    #12;
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_diff",      {16'b0, diff},      32'd0);
    chk("rst_bout",      {31'b0, bout},      32'd0);
    chk("rst_ovf",       {31'b0, ovf},       32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, rd, rbo, rov, rlat);
      chk({vecs[i].nm, "_lat"},  rlat,             32'd4);
      chk({vecs[i].nm, "_diff"}, {16'b0, rd},      {16'b0, vecs[i].d});
      chk({vecs[i].nm, "_bout"}, {31'b0, rbo},     {31'b0, vecs[i].bo});
      chk({vecs[i].nm, "_ovf"},  {31'b0, rov},     {31'b0, vecs[i].ov});
      @(negedge clk);
      chk({vecs[i].nm, "_idle_valid"}, {31'b0, out_valid}, 32'd0);
      chk({vecs[i].nm, "_idle_ready"}, {31'b0, in_ready},  32'd1);
    end

    // Back-pressure: result held while out_ready is low; in_valid in DONE ignored.
    out_ready = 1'b0;
    run_op(16'h0010, 16'h0020, rd, rbo, rov, rlat);
    chk("bp_diff", {16'b0, rd}, 32'h0000FFF0);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        a = 16'h1234;
        b = 16'h0000;
        in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_diff_hold", {16'b0, diff},      32'h0000FFF0);
      chk("bp_bout_hold", {31'b0, bout},      32'd1);
      chk("bp_ovf_hold",  {31'b0, ovf},       32'd0);
      chk("bp_in_ready",  {31'b0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_release_ready", {31'b0, in_ready},  32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("bp_no_phantom_op", {31'b0, in_ready},  32'd1);

    // Reset mid-RUN aborts; next op starts with a clean borrow.
    @(negedge clk);
    a = 16'hAAAA;
    b = 16'h5555;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("mid_run_busy", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_in_ready",  {31'b0, in_ready},  32'd1);
    chk("abort_diff",      {16'b0, diff},      32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_held_valid", {31'b0, out_valid}, 32'd0);
    rst_n = 1'b1;
    run_op(16'h0005, 16'h0003, rd, rbo, rov, rlat);
    chk("post_rst_lat",  rlat,          32'd4);
    chk("post_rst_diff", {16'b0, rd},   32'h00000002);
    chk("post_rst_bout", {31'b0, rbo},  32'd0);
    chk("post_rst_ovf",  {31'b0, rov},  32'd0);
    @(negedge clk);

    // Throughput: 8 random pairs streamed with out_ready high.
    begin
      int sent;
      int got;
      int last_cyc;
      logic [16:0] full;
      logic [15:0] ra;
      logic [15:0] rb;
      logic [15:0] ed;
      sent = 0;
      got = 0;
      last_cyc = 0;
      for (int t = 0; t < 200 && got < 8; t++) begin
        @(negedge clk);
        if (out_valid) begin
          chk("stream_diff", {16'b0, diff}, {16'b0, q_d.pop_front()});
          chk("stream_bout", {31'b0, bout}, {31'b0, q_bo.pop_front()});
          chk("stream_ovf",  {31'b0, ovf},  {31'b0, q_ov.pop_front()});
          if (got > 0) chk("stream_interval", cyc - last_cyc, 32'd6);
          last_cyc = cyc;
          got++;
        end
        if (in_ready && sent < 8) begin
          ra = 16'($urandom);
          rb = 16'($urandom);
          full = {1'b0, ra} - {1'b0, rb};
          ed = full[15:0];
          a = ra;
          b = rb;
          in_valid = 1'b1;
          q_d.push_back(ed);
          q_bo.push_back(full[16]);
          q_ov.push_back((ra[15] != rb[15]) && (ed[15] != ra[15]));
          sent++;
        end else begin
          in_valid = 1'b0;
        end
      end
      in_valid = 1'b0;
      chk("stream_count", got, 32'd8);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
